// File: rtl/fun_arbiter.sv
// fun_arbiter: round-robin front end sharing one fun unit (y = sqrt(a + b^3))
// among N_REQ requesters, with a start/busy handshake and a watchdog.
//
// state    | meaning
// IDLE     | waiting for a pending request while the fun unit is idle
// ISSUE    | operands latched, fun_start_o high for this one cycle
// WAIT_HI  | waiting (at most two cycles) for fun_busy_i to rise
// WAIT_LO  | fun unit running, watchdog counts down until busy falls
// DONE     | done_o[idx] and err_o pulse, pointer moves past the winner
module fun_arbiter #(
   parameter int N_REQ       = 4,
   parameter int W           = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [N_REQ*W-1:0] a_bi,
   input  logic [N_REQ*W-1:0] b_bi,
   output logic [N_REQ-1:0]   done_o,
   output logic [W-1:0]       result_bo,
   output logic               err_o,
   output logic               busy_o,
   output logic               fun_start_o,
   output logic [W-1:0]       fun_a_bo,
   output logic [W-1:0]       fun_b_bo,
   input  logic               fun_busy_i,
   input  logic [W-1:0]       fun_y_bi
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // Watchdog only ever holds values up to TIMEOUT_CYC-1 (TIMEOUT_CYC >= 2).
   localparam int WD_W  = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       fun_a_q, fun_a_d;
   logic [W-1:0]       fun_b_q, fun_b_d;
   logic [W-1:0]       result_q, result_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;
   logic               start_q, start_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic [N_REQ-1:0]   pend;
   logic               gnt_vld;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   cand;

   // A requester whose done pulse is showing is not yet asking for a new op.
   assign pend = req_i & ~done_q;

   // Round-robin pick: first pending request at ptr, ptr+1, ... wrapping at N_REQ.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (int'(ptr_q) + i >= N_REQ) cand = IDX_W'(int'(ptr_q) + i - N_REQ);
         else                          cand = IDX_W'(int'(ptr_q) + i);
         if (!gnt_vld && pend[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Next-state and next-output logic; the watchdog is a down-counter that
   // times out when it reaches zero while busy is still in the wrong level.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      fun_a_d  = fun_a_q;
      fun_b_d  = fun_b_q;
      result_d = result_q;
      wdog_d   = wdog_q;
      start_d  = 1'b0;
      done_d   = '0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            // A leftover busy (e.g. after a timeout) blocks any new issue.
            if (gnt_vld && !fun_busy_i) begin
               idx_d   = gnt_idx;
               fun_a_d = a_bi[int'(gnt_idx)*W +: W];
               fun_b_d = b_bi[int'(gnt_idx)*W +: W];
               start_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wdog_d  = WD_W'(1);
            state_d = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (fun_busy_i) begin
               wdog_d  = WD_W'(TIMEOUT_CYC - 1);
               state_d = ST_WAIT_LO;
            end else if (wdog_q == '0) begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = N_REQ'(1) << idx_q;
               state_d  = ST_DONE;
            end else begin
               wdog_d = wdog_q - 1'b1;
            end
         end
         ST_WAIT_LO: begin
            if (!fun_busy_i) begin
               result_d = fun_y_bi;
               done_d   = N_REQ'(1) << idx_q;
               state_d  = ST_DONE;
            end else if (wdog_q == '0) begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = N_REQ'(1) << idx_q;
               state_d  = ST_DONE;
            end else begin
               wdog_d = wdog_q - 1'b1;
            end
         end
         ST_DONE: begin
            ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            wdog_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);

   // State and registered outputs; reset abandons any op in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         fun_a_q  <= '0;
         fun_b_q  <= '0;
         result_q <= '0;
         wdog_q   <= '0;
         start_q  <= 1'b0;
         done_q   <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         fun_a_q  <= fun_a_d;
         fun_b_q  <= fun_b_d;
         result_q <= result_d;
         wdog_q   <= wdog_d;
         start_q  <= start_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign done_o      = done_q;
   assign result_bo   = result_q;
   assign err_o       = err_q;
   assign busy_o      = busy_q;
   assign fun_start_o = start_q;
   assign fun_a_bo    = fun_a_q;
   assign fun_b_bo    = fun_b_q;

endmodule

// File: tb/tb_fun_arbiter.sv
// Bench for fun_arbiter: behavioural fun unit, directed vector table,
// multi-cycle corner sequences and a randomized run against a round-robin model.
module tb_fun_arbiter;

   localparam int N_REQ       = 4;
   localparam int W           = 8;
   localparam int TIMEOUT_CYC = 64;

   logic               clk_i     = 1'b0;
   logic               rst_ni    = 1'b0;
   logic               fun_rst_n = 1'b0;
   logic [N_REQ-1:0]   req_i     = '0;
   logic [N_REQ*W-1:0] a_bi      = '0;
   logic [N_REQ*W-1:0] b_bi      = '0;
   logic [N_REQ-1:0]   done_o;
   logic [W-1:0]       result_bo;
   logic               err_o;
   logic               busy_o;
   logic               fun_start_o;
   logic [W-1:0]       fun_a_bo;
   logic [W-1:0]       fun_b_bo;
   logic               fun_busy_i;
   logic [W-1:0]       fun_y_bi;

   fun_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .a_bi        (a_bi),
      .b_bi        (b_bi),
      .done_o      (done_o),
      .result_bo   (result_bo),
      .err_o       (err_o),
      .busy_o      (busy_o),
      .fun_start_o (fun_start_o),
      .fun_a_bo    (fun_a_bo),
      .fun_b_bo    (fun_b_bo),
      .fun_busy_i  (fun_busy_i),
      .fun_y_bi    (fun_y_bi)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, starts = 0, dones = 0, last_start = -1, last_done = -1;

   // Integer square root of a + b^3.
   function automatic logic [W-1:0] fun_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      longint av, bv, v, r;
      av = a;
      bv = b;
      v  = av + bv * bv * bv;
      r  = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return W'(r);
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input int k);
      logic [N_REQ-1:0] r;
      r    = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   // Fun unit model: mode 0 busy for fun_lat cycles, mode 1 busy stuck for 100
   // cycles, mode 2 ignores start. Reads a/b live when it finishes.
   int fun_mode = 0;
   int fun_lat  = 3;
   int fun_cnt;
   always @(posedge clk_i or negedge fun_rst_n) begin
      if (!fun_rst_n) begin
         fun_busy_i <= 1'b0;
         fun_y_bi   <= '0;
         fun_cnt    <= 0;
      end else if (fun_busy_i) begin
         if (fun_cnt <= 1) begin
            fun_busy_i <= 1'b0;
            fun_y_bi   <= (fun_mode == 1) ? W'(8'hA5) : fun_ref(fun_a_bo, fun_b_bo);
         end else begin
            fun_cnt <= fun_cnt - 1;
         end
      end else if (fun_start_o && fun_mode != 2) begin
         fun_busy_i <= 1'b1;
         fun_cnt    <= (fun_mode == 1) ? 100 : fun_lat;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s at cycle %0d", name, why, cyc);
   endtask

   // Advance one clock; outputs are looked at 1ns after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
      if (fun_start_o) begin
         starts++;
         last_start = cyc;
      end
      if (done_o != '0) begin
         dones++;
         last_done = cyc;
      end
   endtask

   task automatic wait_done(input string name, input int budget,
                            output logic [N_REQ-1:0] d, output logic [W-1:0] r, output logic e);
      int n;
      n = 0;
      d = '0;
      r = '0;
      e = 1'b0;
      do begin
         step();
         n++;
      end while (done_o == '0 && n < budget);
      if (done_o == '0) fail_now(name, $sformatf("done_o stayed 0 for %0d cycles, expected a pulse", budget));
      else begin
         d = done_o;
         r = result_bo;
         e = err_o;
      end
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      fun_rst_n = 1'b0;
      req_i     = '0;
      fun_mode  = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni    = 1'b1;
      fun_rst_n = 1'b1;
   endtask

   task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      a_bi[k*W +: W] = a;
      b_bi[k*W +: W] = b;
   endtask

   typedef struct {
      int           idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic [W-1:0] y;
   } vec_t;

   vec_t vecs[8];

   task automatic run_single(input vec_t v);
      logic [N_REQ-1:0] d;
      logic [W-1:0]     r;
      logic             e;
      int               s0;
      s0      = starts;
      fun_lat = v.lat;
      set_op(v.idx, v.a, v.b);
      req_i = onehot(v.idx);
      wait_done("single_wait", 200, d, r, e);
      req_i = '0;
      check("single_done_o", d, onehot(v.idx));
      check("single_result", r, v.y);
      check("single_err", e, 0);
      check("single_start_pulses", starts - s0, 1);
      check("single_latency", last_done - last_start, v.lat + 2);
      check("done_busy_o", busy_o, 1);
      step();
      check("idle_busy_o", busy_o, 0);
      check("idle_done_o", done_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N_REQ-1:0]   d;
      logic [W-1:0]       r;
      logic               e;
      int                 s0, d0, n, prev_done, exp_k;
      logic [N_REQ-1:0]   req_prev;
      logic [N_REQ*W-1:0] a_prev, b_prev;
      int                 mptr, exp_idx, exp_start, exp_lat, k, winner;
      logic [W-1:0]       exp_a, exp_b, exp_y;
      logic               done_now, should_grant;

      vecs[0] = '{0, 8'd8,   8'd2,  3, 8'd4};
      vecs[1] = '{1, 8'd9,   8'd3,  1, 8'd6};
      vecs[2] = '{2, 8'd44,  8'd5,  5, 8'd13};
      vecs[3] = '{3, 8'd0,   8'd0,  2, 8'd0};
      vecs[4] = '{1, 8'd255, 8'd0,  7, 8'd15};
      vecs[5] = '{3, 8'd0,   8'd39, 4, 8'd243};
      vecs[6] = '{0, 8'd200, 8'd20, 1, 8'd90};
      vecs[7] = '{2, 8'd255, 8'd39, 8, 8'd244};

      // Reset values
      do_reset();
      check("rst_done_o", done_o, 0);
      check("rst_result", result_bo, 0);
      check("rst_err", err_o, 0);
      check("rst_busy_o", busy_o, 0);
      check("rst_start", fun_start_o, 0);
      check("rst_fun_a", fun_a_bo, 0);
      check("rst_fun_b", fun_b_bo, 0);

      // Single-requester vector table
      for (int i = 0; i < 8; i++) run_single(vecs[i]);

      // All four request at once after reset: served 0,1,2,3 exactly once
      do_reset();
      fun_lat = 4;
      for (int i = 0; i < 4; i++) set_op(vecs[i].idx, vecs[i].a, vecs[i].b);
      req_i = 4'b1111;
      for (int j = 0; j < 4; j++) begin
         wait_done("all4_wait", 100, d, r, e);
         check("all4_order", d, onehot(j));
         check("all4_result", r, vecs[j].y);
         check("all4_err", e, 0);
         req_i = req_i & ~d;
      end
      d0 = dones;
      repeat (20) step();
      check("all4_no_extra_done", dones - d0, 0);

      // req0 and req2 held: alternate 0,2 with back-to-back issue
      do_reset();
      fun_lat = 2;
      set_op(0, 8'd8, 8'd2);
      set_op(2, 8'd44, 8'd5);
      req_i     = 4'b0101;
      prev_done = -1;
      for (int j = 0; j < 8; j++) begin
         wait_done("rr_wait", 100, d, r, e);
         exp_k = (j % 2 == 0) ? 0 : 2;
         check("rr_grant", d, onehot(exp_k));
         check("rr_result", r, (exp_k == 0) ? 4 : 13);
         if (j > 0) check("rr_back_to_back", last_start - prev_done, 2);
         prev_done = last_done;
      end
      req_i = '0;
      repeat (3) step();

      // Busy stuck high 100 cycles: watchdog expires, no reissue while busy
      do_reset();
      fun_mode = 1;
      set_op(0, 8'd8, 8'd2);
      req_i = 4'b0001;
      wait_done("tmo_wait", 200, d, r, e);
      check("tmo_done_o", d, 4'b0001);
      check("tmo_err", e, 1);
      check("tmo_result", r, 0);
      check("tmo_latency", last_done - last_start, TIMEOUT_CYC + 2);
      fun_mode = 0;
      fun_lat  = 3;
      s0 = starts;
      n  = 0;
      while (fun_busy_i && n < 100) begin
         step();
         n++;
      end
      check("tmo_busy_released", fun_busy_i, 0);
      check("tmo_no_start_while_busy", starts - s0, 0);
      step();
      check("tmo_restart", fun_start_o, 1);
      wait_done("tmo_recover_wait", 50, d, r, e);
      check("tmo_recover_result", r, 4);
      check("tmo_recover_err", e, 0);
      req_i = '0;
      step();

      // Busy never rises: error done 3 cycles after start
      do_reset();
      fun_mode = 2;
      set_op(1, 8'd9, 8'd3);
      req_i = 4'b0010;
      wait_done("dead_wait", 50, d, r, e);
      check("dead_done_o", d, 4'b0010);
      check("dead_err", e, 1);
      check("dead_result", r, 0);
      check("dead_latency", last_done - last_start, 3);
      fun_mode = 0;
      req_i    = '0;
      step();
      check("dead_err_one_cycle", err_o, 0);

      // Reset during WAIT_LO: outputs clear at once, op abandoned, ptr back to 0
      do_reset();
      run_single(vecs[2]);
      fun_lat = 20;
      req_i   = 4'b0100;
      n = 0;
      while (!fun_start_o && n < 20) begin
         step();
         n++;
      end
      check("rst_mid_started", fun_start_o, 1);
      repeat (4) step();
      check("pre_rst_busy_o", busy_o, 1);
      check("pre_rst_result_held", result_bo, 13);
      check("pre_rst_fun_a", fun_a_bo, 44);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_rst_busy_o", busy_o, 0);
      check("async_rst_result", result_bo, 0);
      check("async_rst_fun_a", fun_a_bo, 0);
      check("async_rst_fun_b", fun_b_bo, 0);
      check("async_rst_done_err", {done_o, err_o, fun_start_o}, 0);
      d0 = dones;
      repeat (3) step();
      rst_ni = 1'b1;
      fun_lat = 3;
      set_op(0, 8'd8, 8'd2);
      set_op(3, 8'd0, 8'd0);
      req_i = 4'b1111;
      wait_done("post_rst_wait", 100, d, r, e);
      check("post_rst_grant_ptr0", d, 4'b0001);
      check("post_rst_result", r, 4);
      check("post_rst_single_done", dones - d0, 1);
      req_i = '0;
      repeat (3) step();

      // Randomized traffic against a round-robin reference model
      do_reset();
      mptr     = 0;
      exp_idx  = -1;
      exp_start = 0;
      exp_lat  = 0;
      exp_y    = '0;
      done_now = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         req_prev     = req_i;
         a_prev       = a_bi;
         b_prev       = b_bi;
         should_grant = (exp_idx < 0) && !done_now && !fun_busy_i && (req_i != '0);
         step();
         done_now = 1'b0;
         if (should_grant) check("rnd_grant_taken", fun_start_o, 1);
         if (fun_start_o) begin
            check("rnd_start_when_free", exp_idx, -1);
            k = -1;
            for (int j = 0; j < N_REQ; j++)
               if (k < 0 && req_prev[(mptr + j) % N_REQ]) k = (mptr + j) % N_REQ;
            if (k < 0) fail_now("rnd_start_has_req", "fun_start_o=1 with no pending request, expected 0");
            else begin
               exp_idx   = k;
               exp_a     = a_prev[k*W +: W];
               exp_b     = b_prev[k*W +: W];
               exp_y     = fun_ref(exp_a, exp_b);
               exp_start = cyc;
               check("rnd_fun_a", fun_a_bo, exp_a);
               check("rnd_fun_b", fun_b_bo, exp_b);
               fun_lat = $urandom_range(1, 8);
               exp_lat = fun_lat;
               if ($urandom_range(0, 1) == 1) set_op(k, W'($urandom_range(0, 255)), W'($urandom_range(0, 39)));
            end
         end
         if (done_o != '0) begin
            done_now = 1'b1;
            if (exp_idx < 0) fail_now("rnd_done_expected", $sformatf("done_o=%b with no op outstanding, expected 0", done_o));
            else begin
               check("rnd_done_o", done_o, onehot(exp_idx));
               check("rnd_result", result_bo, exp_y);
               check("rnd_err", err_o, 0);
               check("rnd_latency", cyc - exp_start, exp_lat + 2);
               winner  = exp_idx;
               mptr    = (exp_idx + 1) % N_REQ;
               exp_idx = -1;
               if (c < 2900 && $urandom_range(0, 1) == 1)
                  set_op(winner, W'($urandom_range(0, 255)), W'($urandom_range(0, 39)));
               else
                  req_i[winner] = 1'b0;
            end
         end
         for (int j = 0; j < N_REQ; j++) begin
            if (!req_i[j] && c < 2900 && $urandom_range(0, 3) == 0) begin
               set_op(j, W'($urandom_range(0, 255)), W'($urandom_range(0, 39)));
               req_i[j] = 1'b1;
            end
         end
      end
      check("rnd_drained", exp_idx, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
